// File: rtl/lsu_dc_arb.sv
// Round-robin 2:1 arbiter from the LSU ports onto the L1 D-cache request port, with an
// in-order ID FIFO that steers responses back. Define LSU_ARB_LOAD_PRIO_EN for load priority.
module lsu_dc_arb #(
    parameter int unsigned ADDR_W          = 64,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 8
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  logic [1:0]          req_is_write_i,
    input  logic [ADDR_W-1:0]   req_addr_i  [2],
    input  logic [DATA_W-1:0]   req_wdata_i [2],
    input  logic [DATA_W/8-1:0] req_wstrb_i [2],

    output logic                dc_req_valid_o,
    input  logic                dc_req_ready_i,
    output logic                dc_req_is_write_o,
    output logic [ADDR_W-1:0]   dc_req_addr_o,
    output logic [DATA_W-1:0]   dc_req_wdata_o,
    output logic [DATA_W/8-1:0] dc_req_wstrb_o,

    input  logic                dc_rsp_valid_i,
    input  logic [DATA_W-1:0]   dc_rsp_rdata_i,

    output logic [1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o [2],
    output logic                err_o
);

    localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

    if ((MAX_OUTSTANDING < 2) || ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) ||
        (STARVE_LIMIT < 1)) begin : g_bad_cfg
        $error("lsu_dc_arb: MAX_OUTSTANDING must be a power of 2 >= 2, STARVE_LIMIT >= 1");
    end

    logic                 rr_ptr_q;
    logic [CntW-1:0]      count_q;
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [MAX_OUTSTANDING-1:0] id_fifo_q;

    logic stage_free;
    logic slot_free;
    logic grant;
    logic win;
    logic push;
    logic pop;
    logic head;

    // No bypass: a pop in this cycle does not free a slot for this cycle's grant.
    assign stage_free = !dc_req_valid_o || dc_req_ready_i;
    assign slot_free  = count_q < CntW'(MAX_OUTSTANDING);
    assign grant      = stage_free && slot_free && (|req_valid_i) && !rst;

`ifdef LSU_ARB_LOAD_PRIO_EN
    localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 1);

    logic [WaitW-1:0] wait_q [2];
    logic [1:0]       starved;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            starved[p] = req_is_write_i[p] && (wait_q[p] >= WaitW'(STARVE_LIMIT));
        end
    end

    // Counters saturate at the limit; only the >= test matters after that.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '{default: '0};
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (req_ready_o[p]) begin
                    wait_q[p] <= '0;
                end else if (req_valid_i[p] && (wait_q[p] < WaitW'(STARVE_LIMIT))) begin
                    wait_q[p] <= wait_q[p] + WaitW'(1);
                end
            end
        end
    end
`endif

    always_comb begin
        win = rr_ptr_q;
        case (req_valid_i)
            2'b01: win = 1'b0;
            2'b10: win = 1'b1;
            2'b11: begin
                win = rr_ptr_q;
`ifdef LSU_ARB_LOAD_PRIO_EN
                if (starved == 2'b01) begin
                    win = 1'b0;
                end else if (starved == 2'b10) begin
                    win = 1'b1;
                end else if ((starved == 2'b00) && (req_is_write_i[0] ^ req_is_write_i[1])) begin
                    // Load beats store: the winner is the port that is not writing.
                    win = req_is_write_i[0];
                end
`endif
            end
            default: win = rr_ptr_q;
        endcase
    end

    always_comb begin
        req_ready_o = 2'b00;
        if (grant) begin
            req_ready_o[win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else if (grant) begin
            rr_ptr_q <= !win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dc_req_valid_o    <= 1'b0;
            dc_req_is_write_o <= 1'b0;
            dc_req_addr_o     <= '0;
            dc_req_wdata_o    <= '0;
            dc_req_wstrb_o    <= '0;
        end else if (grant) begin
            dc_req_valid_o    <= 1'b1;
            dc_req_is_write_o <= req_is_write_i[win];
            dc_req_addr_o     <= req_addr_i[win];
            dc_req_wdata_o    <= req_wdata_i[win];
            dc_req_wstrb_o    <= req_wstrb_i[win];
        end else if (dc_req_ready_i) begin
            dc_req_valid_o    <= 1'b0;
        end
    end

    assign push = grant;
    assign pop  = dc_rsp_valid_i && (count_q != '0);
    assign head = id_fifo_q[rd_ptr_q];

    // Pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_fifo_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            if (push) begin
                id_fifo_q[wr_ptr_q] <= win;
                wr_ptr_q            <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_o <= 2'b00;
            rsp_rdata_o <= '{default: '0};
            err_o       <= 1'b0;
        end else begin
            rsp_valid_o <= 2'b00;
            if (pop) begin
                rsp_valid_o[head] <= 1'b1;
                rsp_rdata_o[head] <= dc_rsp_rdata_i;
            end
            if (dc_rsp_valid_i && (count_q == '0)) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_dc_arb.sv
// Scoreboard bench for lsu_dc_arb: a transaction-level model predicts grants, cache requests
// and routed responses; a monitor compares them against the DUT every cycle.
module tb_lsu_dc_arb;

    localparam int MAXO   = 4;
    localparam int STARVE = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_is_write;
    logic [63:0] req_addr  [2];
    logic [63:0] req_wdata [2];
    logic [7:0]  req_wstrb [2];
    logic        dc_req_valid;
    logic        dc_req_ready;
    logic        dc_req_is_write;
    logic [63:0] dc_req_addr;
    logic [63:0] dc_req_wdata;
    logic [7:0]  dc_req_wstrb;
    logic        dc_rsp_valid;
    logic [63:0] dc_rsp_rdata;
    logic [1:0]  rsp_valid;
    logic [63:0] rsp_rdata [2];
    logic        err;

    lsu_dc_arb #(
        .ADDR_W         (64),
        .DATA_W         (64),
        .MAX_OUTSTANDING(MAXO),
        .STARVE_LIMIT   (STARVE)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_is_write_i   (req_is_write),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .req_wstrb_i      (req_wstrb),
        .dc_req_valid_o   (dc_req_valid),
        .dc_req_ready_i   (dc_req_ready),
        .dc_req_is_write_o(dc_req_is_write),
        .dc_req_addr_o    (dc_req_addr),
        .dc_req_wdata_o   (dc_req_wdata),
        .dc_req_wstrb_o   (dc_req_wstrb),
        .dc_rsp_valid_i   (dc_rsp_valid),
        .dc_rsp_rdata_i   (dc_rsp_rdata),
        .rsp_valid_o      (rsp_valid),
        .rsp_rdata_o      (rsp_rdata),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } dc_t;

    typedef struct {
        int          port;
        logic [63:0] data;
    } rsp_t;

    // Reference model state
    int          oq[$];      // ports of in-flight requests, oldest first
    int unsigned acc_q[$];   // cycle each request was accepted by the cache
    bit          pref     = 1'b0;
    bit          stage_v  = 1'b0;
    int          waitc[2] = '{0, 0};
    bit          err_m    = 1'b0;
    int unsigned cyc      = 0;
    dc_t         dc_exp[$];
    rsp_t        rsp_exp[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        int w;
        if (rst || (req_valid == 2'b00)) return -1;
        if (stage_v && !dc_req_ready) return -1;
        if (oq.size() >= MAXO) return -1;
        if (req_valid == 2'b01) return 0;
        if (req_valid == 2'b10) return 1;
        w = pref ? 1 : 0;
`ifdef LSU_ARB_LOAD_PRIO_EN
        begin
            bit s0, s1;
            s0 = req_is_write[0] && (waitc[0] >= STARVE);
            s1 = req_is_write[1] && (waitc[1] >= STARVE);
            if (s0 && !s1) w = 0;
            else if (s1 && !s0) w = 1;
            else if (!s0 && !s1 && (req_is_write[0] != req_is_write[1]))
                w = req_is_write[0] ? 1 : 0;
        end
`endif
        return w;
    endfunction

    always @(posedge clk) begin : model
        int   g;
        rsp_t r;
        g = model_grant();
        if (rst) begin
            oq.delete();
            acc_q.delete();
            dc_exp.delete();
            pref    = 1'b0;
            stage_v = 1'b0;
            waitc   = '{0, 0};
            err_m   = 1'b0;
        end else begin
            if (stage_v && dc_req_ready) acc_q.push_back(cyc);
            if (dc_rsp_valid) begin
                if (acc_q.size() > 0) void'(acc_q.pop_front());
                if (oq.size() > 0) begin
                    r.port = oq.pop_front();
                    r.data = dc_rsp_rdata;
                    rsp_exp.push_back(r);
                end else begin
                    err_m = 1'b1;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (g == p) waitc[p] = 0;
                else if (req_valid[p]) waitc[p]++;
            end
            if (g >= 0) begin
                oq.push_back(g);
                dc_exp.push_back('{req_is_write[g], req_addr[g], req_wdata[g], req_wstrb[g]});
                pref    = (g == 0);
                stage_v = 1'b1;
            end else if (dc_req_ready) begin
                stage_v = 1'b0;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin : monitor
        int         g;
        logic [1:0] er;
        dc_t        e;
        rsp_t       r;
        #2;
        g  = model_grant();
        er = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
        check("req_ready", req_ready, er);
        check("dc_req_valid", dc_req_valid, stage_v);
        check("err", err, err_m);
        if (dc_req_valid && dc_req_ready && !rst) begin
            if (dc_exp.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL dc_req: unexpected cache request, expected none (t=%0t)", $time);
            end else begin
                e = dc_exp.pop_front();
                check("dc_req_fields", {dc_req_is_write, dc_req_addr, dc_req_wdata, dc_req_wstrb},
                      {e.we, e.addr, e.wdata, e.wstrb});
            end
        end
        if (rsp_valid != 2'b00) begin
            if (rsp_exp.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp: got rsp_valid %b, expected no response (t=%0t)", rsp_valid, $time);
            end else begin
                r = rsp_exp.pop_front();
                check("rsp_valid", rsp_valid, (r.port == 0) ? 2'b01 : 2'b10);
                check("rsp_rdata", rsp_rdata[r.port], r.data);
            end
        end
    end

    task automatic drive(input bit [1:0] v, input bit [1:0] we, input int rdy_pct, input int lat,
                         input bit hold);
        @(negedge clk);
        rst          = 1'b0;
        req_valid    = v;
        req_is_write = we;
        for (int p = 0; p < 2; p++) begin
            req_addr[p]  = {$urandom, $urandom};
            req_wdata[p] = {$urandom, $urandom};
            req_wstrb[p] = 8'($urandom);
        end
        dc_req_ready = ($urandom_range(99) < rdy_pct);
        dc_rsp_valid = !hold && (acc_q.size() > 0) && (cyc >= acc_q[0] + lat);
        dc_rsp_rdata = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        req_valid    = 2'b00;
        dc_req_ready = 1'b0;
        dc_rsp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_dc_req_valid", dc_req_valid, 1'b0);
        check("rst_dc_req_fields", {dc_req_is_write, dc_req_addr, dc_req_wdata, dc_req_wstrb}, '0);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_rdata0", rsp_rdata[0], 64'h0);
        check("rst_rsp_rdata1", rsp_rdata[1], 64'h0);
        check("rst_err", err, 1'b0);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            drive(2'b00, 2'b00, 100, 1, 1'b0);
            if (acc_q.size() == 0 && oq.size() == 0 && !stage_v && rsp_exp.size() == 0)
                done = 1'b1;
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL drain: still busy after 200 cycles, expected idle");
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int grants;
        rst          = 1'b1;
        req_valid    = 2'b00;
        req_is_write = 2'b00;
        dc_req_ready = 1'b0;
        dc_rsp_valid = 1'b0;
        dc_rsp_rdata = '0;
        for (int p = 0; p < 2; p++) begin
            req_addr[p]  = '0;
            req_wdata[p] = '0;
            req_wstrb[p] = '0;
        end
        do_reset();

        // Single load on port 0, 2-cycle cache latency returning 0xDEAD
        drive(2'b01, 2'b00, 100, 2, 1'b0);
        req_addr[0] = 64'h1000;
        repeat (6) begin
            drive(2'b00, 2'b00, 100, 2, 1'b0);
            dc_rsp_rdata = 64'hDEAD;
        end
        drain();

        // Contention
        repeat (6) drive(2'b11, 2'b00, 100, 2, 1'b0);
        drain();

        // Backpressure
        drive(2'b11, 2'b00, 100, 2, 1'b0);
        repeat (3) drive(2'b11, 2'b00, 0, 2, 1'b0);
        repeat (2) drive(2'b11, 2'b00, 100, 2, 1'b0);
        drain();

        // Outstanding limit with responses withheld, then released
        grants = 0;
        repeat (10) begin
            drive(2'b11, 2'b00, 100, 1, 1'b1);
            #1;
            if (req_ready != 2'b00) grants++;
        end
        check("outstanding_grants", grants, MAXO);
        repeat (8) drive(2'b11, 2'b00, 100, 1, 1'b0);
        drain();

        // Randomized traffic with a reset in the middle and a stale response after it
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                do_reset();
                drive(2'b00, 2'b00, 100, 1, 1'b0);
                dc_rsp_valid = 1'b1;
            end
            drive(2'(Alternative_rand()), 2'($urandom_range(3)), 75, $urandom_range(1, 6),
                  ($urandom_range(9) == 0));
        end
        drain();

        // Response with an empty FIFO, then reset clears the sticky error
        do_reset();
        drive(2'b00, 2'b00, 100, 1, 1'b0);
        dc_rsp_valid = 1'b1;
        repeat (3) drive(2'b00, 2'b00, 100, 1, 1'b0);
        #1;
        check("err_sticky", err, 1'b1);
        do_reset();

`ifdef LSU_ARB_LOAD_PRIO_EN
        begin
            int loads;
            bit st_granted;
            loads      = 0;
            st_granted = 1'b0;
            repeat (3) drive(2'b01, 2'b00, 100, 1, 1'b0);
            for (int i = 0; i < 30 && !st_granted; i++) begin
                drive(2'b11, 2'b10, 100, 1, 1'b0);
                #1;
                if (req_ready[1]) st_granted = 1'b1;
                else if (req_ready[0]) loads++;
            end
            check("starve_store_granted", st_granted, 1'b1);
            check("starve_loads_before_store", loads, STARVE);
            repeat (4) drive(2'b01, 2'b00, 100, 1, 1'b0);
            drain();
        end
`endif

        check("dc_exp_empty", dc_exp.size(), 0);
        check("rsp_exp_empty", rsp_exp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    function automatic int Alternative_rand();
        return $urandom_range(3);
    endfunction

endmodule
